seq_mul16: RTL and testbench
============================

# seq_mul16

Sequential 16x16 unsigned shift-and-add multiplier built around one instance of the team's 16-bit ripple-carry adder (`RCA_16bit`). Each cycle the block drives the adder's operand inputs and consumes its `sum`/`cout`. The block is therefore both the adder's upstream operand source and its downstream result consumer. It sits between a register-file or operand source and any datapath needing 32-bit products, trading latency (17 cycles) for area (a single adder).

## Interface
- Parameters: none. Width is fixed at 16 by the adder instance.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE or DONE state.
- a  input  16  multiplicand, unsigned; captured on accepted start.
- b  input  16  multiplier, unsigned; captured on accepted start.
- busy  output  1  registered; high while in BUSY state.
- done  output  1  registered; one-cycle pulse when product becomes valid.
- product  output  32  registered; result of the last completed operation, held until the next completion.

## Operation
- Internal registers:
  - mcand[15:0]
  - hi[15:0] (accumulator)
  - lo[15:0] (multiplier shift register, low product half)
  - cnt[3:0]
  - state ∈ {IDLE, BUSY, DONE}
- Adder hookup (continuous):
  - in_a = hi
  - in_b = lo[0] ? mcand : 16'h0000
  - cin = 0
- Start accepted in IDLE or DONE when start=1:
  - mcand←a, lo←b, hi←0, cnt←0, state←BUSY.
- BUSY, every edge:
  - {hi,lo} ← {cout, sum, lo[15:1]} (add-then-shift-right through carry).
  - cnt←cnt+1.
  - When cnt==15 on this edge: product←{cout, sum, lo[15:1]}, state←DONE.
- DONE lasts exactly one cycle; done=1 only in DONE.
  - Next edge: state←BUSY if start=1 (new operands captured), else IDLE.
- start while BUSY is ignored; operands are not re-captured and no error is flagged.
- Arithmetic: product = a*b exactly, 0 to 0xFFFE0001. No overflow possible; cout is absorbed into hi each step.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, product=32'h0.
  - hi, lo, mcand, cnt cleared.
- Reset mid-operation: everything clears immediately (async). No done pulse. product returns to 0.
- Latency: start sampled at edge E0. busy=1 after E0. Iterations on edges E1..E16. done=1 and product valid after E16 (17 cycles start-to-done).
- Throughput: start held high through the DONE cycle begins the next operation at E17. Back-to-back issue every 17 cycles.
- busy and done are never high simultaneously. busy drops in the same cycle done rises.
- The adder path is combinational within one cycle: hi/mcand → adder → hi register. This is the critical path (16-bit ripple).

## Configuration
- Macro SEQ_MUL16_ZERO_BYPASS_EN.
- Defined: an accepted start with a==0 or b==0 goes directly to DONE.
  - product←0, done=1 after E0 (latency 1).
  - busy never asserts for that operation.
- Undefined: zero operands take the full 17-cycle path and yield product 0.

## Test plan
- a=3, b=5, start pulsed one cycle → busy for 16 cycles, done one cycle at E16, product=32'd15; product still 15 ten cycles later.
- a=16'hFFFF, b=16'hFFFF → product=32'hFFFE0001 at E16.
- a=16'h1234, b=16'h5678; second start with a=1, b=1 pulsed at E5 → ignored; product=32'h0626_0060.
- start held high continuously, a=2, b=7 then a=9, b=9 presented in the DONE cycle → done pulses at E16 (product 14) and E33 (product 81).
- rst asserted asynchronously mid-cycle at E8 of an operation → busy=0, done=0, product=0 immediately; no done pulse; a new start after release works normally.
- a=0, b=16'hABCD → with SEQ_MUL16_ZERO_BYPASS_EN: done after E0, busy never high, product=0. Without it: done at E16, product=0.

Source files
------------

// File: rtl/seq_mul16.sv
// seq_mul16 -- sequential 16x16 unsigned shift-and-add multiplier.
//
// One RCA_16bit instance is reused every cycle. The accumulator (hi) and the
// multiplier shift register (lo) together form the 32-bit partial product.
// Each BUSY cycle does one add-then-shift-right step, and the adder carry-out
// shifts into hi[15]. Sixteen steps give the exact product.
//
// Timing: the start is accepted at edge E0, the iterations happen at edges
// E1..E16, and done pulses for one cycle after E16 with product valid.
//
// Optional feature: define SEQ_MUL16_ZERO_BYPASS_EN so that an accepted start
// with a zero operand goes straight to DONE with product 0. In that case the
// latency is 1 and busy never asserts.

// 16-bit ripple-carry adder (the team's shared adder block).
module RCA_16bit (
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit, carries chained LSB to MSB.
    for (genvar i = 0; i < 16; i++) begin : g_bit
        logic prop;
        assign prop         = in_a[i] ^ in_b[i];
        assign sum[i]       = prop ^ carry[i];
        assign carry[i + 1] = (in_a[i] & in_b[i]) | (carry[i] & prop);
    end

    assign cout = carry[16];

endmodule

module seq_mul16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Datapath registers.
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  cnt;

    // Control strobes decoded from the FSM.
    logic load;     // capture new operands
    logic step;     // one add-then-shift iteration
    logic finish;   // last iteration: publish product
    logic zero_op;  // zero-operand shortcut (only ever set with bypass enabled)

    // Adder hookup and the value {hi,lo} takes after one step.
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_cout;
    logic [31:0] step_val;

    assign add_b    = lo[0] ? mcand : 16'h0000;
    assign step_val = {add_cout, add_sum, lo[15:1]};

    RCA_16bit u_rca (
        .in_a (hi),
        .in_b (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments, so every register
        // samples its pre-edge value. Blocking assignments here would create
        // ordering races between always_ff blocks.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // leaves one unassigned would infer a latch.
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        zero_op   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load = 1'b1;
`ifdef SEQ_MUL16_ZERO_BYPASS_EN
                    if ((a == 16'h0000) || (b == 16'h0000)) begin
                        zero_op   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                    end
`else
                    state_nxt = BUSY;
`endif
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end

            BUSY: begin
                // start is deliberately ignored while an operation runs.
                step = 1'b1;
                if (cnt == 4'd15) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered status flags, derived from the next state so that they line
    // up exactly with the state they report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == BUSY);
            done <= (state_nxt == DONE);
        end
    end

    // Operand capture and the shift-and-add iteration.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: these are a handful of flops rather than a memory, so all of
        // them are reset. A reset in mid-operation then leaves no stale
        // partial product behind.
        if (rst) begin
            mcand <= 16'h0000;
            hi    <= 16'h0000;
            lo    <= 16'h0000;
            cnt   <= 4'd0;
        end else if (load) begin
            mcand <= a;
            lo    <= b;
            hi    <= 16'h0000;
            cnt   <= 4'd0;
        end else if (step) begin
            {hi, lo} <= step_val;
            cnt      <= cnt + 4'd1;
        end
    end

    // Result register: updated only on completion, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= 32'h0000_0000;
        end else if (finish) begin
            product <= step_val;
        end else if (zero_op) begin
            product <= 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_seq_mul16.sv
// tb_seq_mul16 -- directed, table-driven bench for seq_mul16.
// Expected products are hand-computed constants. Expected latency depends on
// whether SEQ_MUL16_ZERO_BYPASS_EN is defined for the build.
module tb_seq_mul16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SEQ_MUL16_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [31:0] exp_prod;
    } vec_t;

    vec_t vecs [10];

    seq_mul16 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at the negedge after the accepting edge. It counts further edges
    // until done is seen, or until a bounded budget runs out.
    task automatic wait_done(input int lat0, output int lat, output int busy_n,
                             output bit both, output bit timeout);
        lat     = lat0;
        busy_n  = 0;
        both    = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) both = 1'b1;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    // Full single operation, entered and left at a negedge.
    task automatic run_op(input string name, input logic [15:0] va,
                          input logic [15:0] vb, input logic [31:0] exp_prod);
        int lat, busy_n, exp_lat;
        bit both, timeout;
        exp_lat = (BYPASS && (va == 16'h0 || vb == 16'h0)) ? 0 : 16;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(0, lat, busy_n, both, timeout);
        check({name, "_timeout"}, 32'(timeout), 32'd0);
        check({name, "_prod"}, product, exp_prod);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        check({name, "_busy_and_done"}, 32'(both), 32'd0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, busy_n, done_n;
        bit both, timeout;

        vecs[0] = '{16'd3,    16'd5,    32'd15};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[3] = '{16'h0001, 16'h0001, 32'h0000_0001};
        vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[5] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[6] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE};
        vecs[7] = '{16'h1234, 16'h0010, 32'h0001_2340};
        vecs[8] = '{16'h0000, 16'hABCD, 32'h0000_0000};
        vecs[9] = '{16'h1234, 16'h0000, 32'h0000_0000};

        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", product, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic op, then the product must hold with no further activity.
        run_op("mul_3x5", 16'd3, 16'd5, 32'd15);
        repeat (10) @(negedge clk);
        check("hold_product", product, 32'd15);
        check("hold_idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_prod);
        end

        // A second start at E5 is ignored; the original operands finish.
        a     = 16'h1234;
        b     = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        a     = 16'h0001;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        wait_done(5, lat, busy_n, both, timeout);
        check("ignore_timeout", 32'(timeout), 32'd0);
        check("ignore_prod", product, 32'h0626_0060);
        check("ignore_latency", 32'(lat), 32'd16);
        @(negedge clk);

        // start held high: the second op begins in the DONE cycle, so done
        // pulses at E16 and again at E33.
        a     = 16'd2;
        b     = 16'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(0, lat, busy_n, both, timeout);
        check("b2b_first_timeout", 32'(timeout), 32'd0);
        check("b2b_first_prod", product, 32'd14);
        check("b2b_first_latency", 32'(lat), 32'd16);
        a = 16'd9;
        b = 16'd9;
        @(posedge clk);
        @(negedge clk);
        wait_done(0, lat, busy_n, both, timeout);
        start = 1'b0;
        check("b2b_second_timeout", 32'(timeout), 32'd0);
        check("b2b_second_prod", product, 32'd81);
        check("b2b_second_latency", 32'(lat), 32'd16);
        check("b2b_second_busy_cycles", 32'(busy_n), 32'd16);
        check("b2b_busy_and_done", 32'(both), 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of the cycle after E8.
        a     = 16'h1234;
        b     = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", product, 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        check("midrst_no_done", 32'(done_n), 32'd0);
        run_op("after_rst", 16'h00FF, 16'h0100, 32'h0000_FF00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
